// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined RV32I control path: opcodes, control
// field enums and the per-stage control word carried through ID/EX, EX/MEM, MEM/WB.
package ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLT   = 4'd5,
      ALU_SLTU  = 4'd6,
      ALU_SLL   = 4'd7,
      ALU_SRL   = 4'd8,
      ALU_SRA   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_t;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'b00,
      PC_TARGET = 2'b01,
      PC_ALU    = 2'b10
   } pc_src_t;

   typedef struct packed {
      logic        reg_write;
      result_src_t result_src;
      logic        mem_write;
      logic        jump;
      logic        branch;
      logic [2:0]  func3;
      alu_op_t     alu_control;
      logic        alu_src_a;
      logic        alu_src_b;
   } ctrl_word_t;

   localparam int         CTRL_W      = $bits(ctrl_word_t);
   localparam ctrl_word_t CTRL_BUBBLE = '0;

   // alt selects SUB/SRA; callers qualify it per instruction class.
   function automatic alu_op_t alu_from_func3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decode: instruction -> control word, immediate format
// and illegal flag. Illegal encodings come out as a bubble.
module instr_decoder
   import ctrl_pkg::*;
(
   input  logic [31:0]       instr_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [2:0]        imm_src_o,
   output logic              illegal_o
);

   logic [6:0] opcode;
   logic [6:0] func7;
   logic [2:0] func3;
   ctrl_word_t w;
   imm_src_t   imm;
   logic       ill;
   logic       unused_fields;

   assign opcode        = instr_i[6:0];
   assign func3         = instr_i[14:12];
   assign func7         = instr_i[31:25];
   assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

   always_comb begin
      w       = CTRL_BUBBLE;
      imm     = IMM_I;
      ill     = 1'b0;
      w.func3 = func3;
      case (opcode)
         OP_R: begin
            w.reg_write   = 1'b1;
            w.alu_control = alu_from_func3(func3, func7[5]);
            ill = !((func7 == 7'b0000000) ||
                    ((func7 == 7'b0100000) && ((func3 == 3'b000) || (func3 == 3'b101))));
         end
         OP_IMM: begin
            w.reg_write   = 1'b1;
            w.alu_src_b   = 1'b1;
            // func7 is immediate data except on shifts, so ADDI never becomes SUB
            w.alu_control = alu_from_func3(func3, func7[5] & (func3 == 3'b101));
            if (func3 == 3'b001)
               ill = (func7 != 7'b0000000);
            else if (func3 == 3'b101)
               ill = (func7 != 7'b0000000) && (func7 != 7'b0100000);
         end
         OP_LOAD: begin
            w.reg_write  = 1'b1;
            w.result_src = RES_MEM;
            w.alu_src_b  = 1'b1;
            ill          = (func3 != 3'b010);
         end
         OP_STORE: begin
            w.mem_write = 1'b1;
            w.alu_src_b = 1'b1;
            imm         = IMM_S;
            ill         = (func3 != 3'b010);
         end
         OP_BRANCH: begin
            w.branch      = 1'b1;
            w.alu_control = ALU_SUB;
            imm           = IMM_B;
            ill           = (func3[2:1] == 2'b01);
         end
         OP_JAL: begin
            w.reg_write  = 1'b1;
            w.result_src = RES_PC4;
            w.jump       = 1'b1;
            imm          = IMM_J;
         end
         OP_JALR: begin
            w.reg_write  = 1'b1;
            w.result_src = RES_PC4;
            w.jump       = 1'b1;
            w.alu_src_b  = 1'b1;
            ill          = (func3 != 3'b000);
         end
         OP_LUI: begin
            w.reg_write   = 1'b1;
            w.alu_control = ALU_PASSB;
            w.alu_src_b   = 1'b1;
            imm           = IMM_U;
         end
         OP_AUIPC: begin
            w.reg_write = 1'b1;
            w.alu_src_a = 1'b1;
            w.alu_src_b = 1'b1;
            imm         = IMM_U;
         end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         w   = CTRL_BUBBLE;
         imm = IMM_I;
      end
   end

   assign ctrl_o    = w;
   assign imm_src_o = imm;
   assign illegal_o = ill;

endmodule

// File: rtl/pipelined_control_unit.sv
// Five-stage RV32I control path: decode, ID/EX, EX/MEM, MEM/WB control
// registers and Execute-stage branch/jump resolution with self-generated flushes.
module pipelined_control_unit
   import ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W   = 4,
   parameter bit TRAP_ILLEGAL = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           instr_d,
   input  logic                  flush_e_in,
   input  logic                  zero_e,
   input  logic                  lt_e,
   input  logic                  ltu_e,
   output logic [2:0]            imm_src_d,
   output logic                  illegal_d,
   output logic [ALU_CTRL_W-1:0] alu_control_e,
   output logic                  alu_src_a_e,
   output logic                  alu_src_b_e,
   output logic [1:0]            pc_src_e,
   output logic                  flush_d,
   output logic                  flush_e,
   output logic [1:0]            result_src_e,
   output logic [1:0]            result_src_m,
   output logic [1:0]            result_src_w,
   output logic                  reg_write_m,
   output logic                  reg_write_w,
   output logic                  mem_write_m
);

   logic [CTRL_W-1:0] dec_bits;
   ctrl_word_t        dec_word;
   logic              dec_illegal;
   ctrl_word_t        ex_d, ex_q, mem_q, wb_q;
   logic              cond_e, taken_e;
   pc_src_t           pc_src;
   logic              unused_trap, unused_fields;

   instr_decoder u_dec (
      .instr_i   (instr_d),
      .ctrl_o    (dec_bits),
      .imm_src_o (imm_src_d),
      .illegal_o (dec_illegal)
   );

   assign dec_word  = ctrl_word_t'(dec_bits);
   // Both policies flag and bubble identically here; trapping is handled downstream.
   assign illegal_d   = dec_illegal;
   assign unused_trap = TRAP_ILLEGAL;

   always_comb begin
      cond_e = 1'b0;
      case (ex_q.func3)
         3'b000:  cond_e = zero_e;
         3'b001:  cond_e = !zero_e;
         3'b100:  cond_e = lt_e;
         3'b101:  cond_e = !lt_e;
         3'b110:  cond_e = ltu_e;
         3'b111:  cond_e = !ltu_e;
         default: cond_e = 1'b0;
      endcase
   end

   assign taken_e = ex_q.jump | (ex_q.branch & cond_e);

   // JALR is the only jump that takes its operand B from the immediate.
   always_comb begin
      pc_src = PC_PLUS4;
      if (ex_q.jump & ex_q.alu_src_b)
         pc_src = PC_ALU;
      else if (taken_e)
         pc_src = PC_TARGET;
   end

   assign ex_d = (flush_e_in | taken_e | dec_illegal) ? CTRL_BUBBLE : dec_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q  <= CTRL_BUBBLE;
         mem_q <= CTRL_BUBBLE;
         wb_q  <= CTRL_BUBBLE;
      end else begin
         ex_q  <= ex_d;
         mem_q <= ex_q;
         wb_q  <= mem_q;
      end
   end

   assign alu_control_e = ALU_CTRL_W'(ex_q.alu_control);
   assign alu_src_a_e   = ex_q.alu_src_a;
   assign alu_src_b_e   = ex_q.alu_src_b;
   assign result_src_e  = ex_q.result_src;
   assign pc_src_e      = pc_src;
   assign flush_d       = taken_e;
   assign flush_e       = taken_e;

   assign result_src_m  = mem_q.result_src;
   assign reg_write_m   = mem_q.reg_write;
   assign mem_write_m   = mem_q.mem_write;
   assign result_src_w  = wb_q.result_src;
   assign reg_write_w   = wb_q.reg_write;

   assign unused_fields = ^{mem_q.jump, mem_q.branch, mem_q.func3, mem_q.alu_control,
                            mem_q.alu_src_a, mem_q.alu_src_b, wb_q.mem_write, wb_q.jump,
                            wb_q.branch, wb_q.func3, wb_q.alu_control, wb_q.alu_src_a,
                            wb_q.alu_src_b};

endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Pipelined RV32I control unit for the five-stage core, replacing the single-cycle control path. The block decodes the instruction in Decode and carries the control word through the ID/EX, EX/MEM and MEM/WB control registers. It resolves all six conditional branch types plus JAL/JALR in Execute and raises its own pipeline flushes. ALU-control width and the illegal-instruction policy are parametrised.

## Interface
- `ALU_CTRL_W`, default 4: width of the ALU control code; must be ≥4.
- `TRAP_ILLEGAL`, default 0: 1 = `illegal_d` asserted and the instruction bubbled; 0 = bubbled silently, `illegal_d` still driven.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_d` in 32: instruction in Decode.
- `flush_e_in` in 1: hazard-unit request (load-use stall) to load a bubble into ID/EX.
- `zero_e`, `lt_e`, `ltu_e` in 1 each: ALU flags for the Execute-stage compare (rs1−rs2).
- `imm_src_d` out 3: immediate format. I=000, S=001, B=010, J=011, U=100.
- `illegal_d` out 1: unsupported opcode/func combination in Decode.
- `alu_control_e` out ALU_CTRL_W: operation code.
- `alu_src_a_e` out 1: 1 = PC (AUIPC).
- `alu_src_b_e` out 1: 1 = immediate.
- `pc_src_e` out 2: 00 = PC+4, 01 = PC+imm (branch/JAL), 10 = ALU result (JALR).
- `flush_d`, `flush_e` out 1: taken control transfer; kill IF/ID and ID/EX.
- `result_src_e`, `result_src_m`, `result_src_w` out 2: 00 = ALU, 01 = memory, 10 = PC+4.
- `reg_write_m`, `reg_write_w` out 1: register-file write enable.
- `mem_write_m` out 1: data-memory write enable.

## Operation
- Supported opcodes: R 0110011, I-ALU 0010011, LW 0000011, SW 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. Anything else is illegal.
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, PASSB 10; upper bits zero-extended.
- SUB is selected only for R-type with func7[5]=1; SRA is selected for func7[5]=1 with func3=101 (R or I).
- Loads, stores, JALR and AUIPC use ADD. LUI uses PASSB. Branches use SUB.
- Control word per stage: {reg_write, result_src, mem_write, jump, branch, func3, alu_control, alu_src_a, alu_src_b}.
- A bubble is an all-zero word, i.e. a NOP with no side effects.
- Branch condition in Execute, selected by registered func3:
  - 000: zero
  - 001: !zero
  - 100: lt
  - 101: !lt
  - 110: ltu
  - 111: !ltu
  - 010/011: never taken; these are also flagged illegal in Decode.
- taken_e = jump_e | (branch_e & cond).
- pc_src_e = 10 for JALR, 01 for other taken transfers, else 00.
- `flush_d = flush_e = taken_e`, combinational.
- ID/EX loads a bubble when flush_e_in | taken_e, or when the Decode instruction is illegal.
- EX/MEM and MEM/WB never stall; they always advance.

## Timing
- Decode outputs (`imm_src_d`, `illegal_d`) are combinational from `instr_d`.
- Execute outputs appear 1 cycle after decode, Memory outputs 2 cycles after, Writeback outputs 3 cycles after.
- Reset (asynchronous) clears all three control registers to bubble:
  - all `_e/_m/_w` outputs 0;
  - `pc_src_e` = 00;
  - `flush_d`/`flush_e` = 0.
- Reset deasserted mid-stream: the first instruction presented after release appears at `_e` one cycle later. No stale state survives reset.
- Simultaneous taken branch in E and flush_e_in: ID/EX still receives a single bubble. The branch itself proceeds to M unchanged.
- Back-to-back taken branches cannot occur, because the flush bubbles the successor.
- `flush_d`/`flush_e` pulse for exactly the cycle the taken instruction is in E.

## Structure
- Package `ctrl_pkg` holds:
  - opcode constants;
  - `alu_op_t`, `imm_src_t`, `result_src_t`, `pc_src_t` enums;
  - packed struct `ctrl_word_t` and `CTRL_BUBBLE` constant.
- Sub-module `instr_decoder`: purely combinational `instr_d` → `ctrl_word_t` + `imm_src` + `illegal`.
- The top level contains the three pipeline registers and the branch-resolution logic.

## Test plan
- ADD x1,x2,x3 (0x003100B3) → `alu_control_e`=0 at +1, `reg_write_w`=1 and `result_src_w`=00 at +3; reset mid-pipeline clears all three stages at once.
- SUB (func7=0100000) → `alu_control_e`=1. SRAI x1,x1,3 → code 9, `alu_src_b_e`=1. LUI → code 10, `imm_src_d`=100. AUIPC → `alu_src_a_e`=1.
- BNE with zero_e=0 → `pc_src_e`=01, `flush_d`=`flush_e`=1 for one cycle, next `_e` outputs all 0. Same with zero_e=1 → no flush.
- BLTU/BGE across all flag combinations → taken exactly per the func3 table.
- JALR → `pc_src_e`=10, `result_src_w`=10. LW → `result_src_m`=01. SW → `mem_write_m`=1, `reg_write_m`=0.
- Opcode 0x7F and branch func3=010 → `illegal_d`=1, bubble observed at E/M/W. flush_e_in during a valid ADD → bubble, no write.
